terrain_probe: RTL and testbench
================================

// Module: terrain_probe
// PURPOSE
//  Per-frame terrain collision probe feeding the ball motion stage. Once per frame it samples a
//  height-map ROM at three columns under the ball (left edge, centre, right edge). It then reports
//  ground contact, penetration depth and left/right wall flags, which the ball stage uses for
//  landing and horizontal blocking. It owns the terrain_addr bus that drives the terrain ROM.
// PARAMETERS
//  COL_SHIFT    2    terrain column = pixel X >> COL_SHIFT (4-px columns, 160 entries)
//  X_MAX        639  rightmost valid pixel X; right probe column clamps here
//  STEP_MAX     4    max terrain rise (px) the ball may climb without a wall flag
//  RD_LATENCY   1    ROM read latency in Clk cycles (legal values 1 or 2)
// PORTS
//  Clk           in   1   system clock; every register is clocked on posedge Clk
//  Reset         in   1   synchronous, active-high reset
//  frame_start   in   1   one-Clk pulse, once per frame; starts a probe
//  BallX         in   10  ball centre X (unsigned px)
//  BallY         in   10  ball centre Y (unsigned px, grows downward)
//  BallS         in   10  ball half-size (px)
//  terrain_addr  out  10  terrain ROM address (registered)
//  terrain_data  in   10  surface Y of addressed column; valid RD_LATENCY cycles after the address
//  probe_valid   out  1   one-cycle pulse: result outputs were updated this cycle
//  ground_y      out  10  surface Y under the centre column
//  grounded      out  1   (BallY+BallS) >= ground_y
//  penetration   out  10  depth of ball bottom below surface, 0 if not grounded
//  wall_left     out  1   left column rises more than STEP_MAX above ball bottom
//  wall_right    out  1   right column rises more than STEP_MAX above ball bottom
//  overrun       out  1   sticky: frame_start arrived while busy
// BEHAVIOUR
//  - Reset (sync): state=IDLE. terrain_addr, probe_valid, ground_y, grounded, penetration,
//    wall_left, wall_right and overrun all go to 0. Captured heights are cleared.
//    Reset mid-probe aborts the probe with no probe_valid pulse.
//  - FSM states: IDLE, ISSUE_L, ISSUE_C, ISSUE_R, DRAIN, RESULT.
//    IDLE   --frame_start--> ISSUE_L. Latch X, Y and S in this cycle; later input changes are ignored.
//    ISSUE_L -> ISSUE_C -> ISSUE_R: one address per cycle (left, centre, right).
//    ISSUE_R -> DRAIN: DRAIN waits until all three reads have returned (RD_LATENCY cycles).
//    DRAIN -> RESULT -> IDLE. probe_valid=1 only in the RESULT cycle.
//  - Latency: with frame_start sampled in cycle 0, probe_valid is high in cycle 4+RD_LATENCY
//    (cycle 5 for the default). A new frame_start is accepted again the cycle after RESULT.
//  - Read tagging: data is captured by a RD_LATENCY-deep tag shift register, not by FSM state.
//    Data returned in cycle N+RD_LATENCY belongs to the address issued in cycle N.
//  - Columns (11-bit arithmetic):
//    colL = (X >= S) ? X-S : 0.  colC = X.  colR = (X+S > X_MAX) ? X_MAX : X+S.
//    terrain_addr = col >> COL_SHIFT, zero-extended. terrain_addr = 0 in IDLE, DRAIN and RESULT.
//  - Results, registered in the RESULT cycle (11-bit compares, bot = Y+S):
//    ground_y = hC.  grounded = bot >= hC.
//    penetration = grounded ? min(bot-hC, 1023) : 0  (saturates).
//    wall_left = (hL+STEP_MAX) < bot.  wall_right = (hR+STEP_MAX) < bot.
//    All result outputs hold until the next RESULT cycle or Reset.
//  - frame_start outside IDLE: ignored and overrun <= 1. overrun stays 1 until Reset.
//    frame_start in the RESULT cycle counts as busy.
//  - Edge cases: S=0 gives three probes of the same column. X=0 clamps left to 0.
//    X=639, S=4 clamps right to 639, which gives addr 159.
// TESTING
//  1 Reset, idle: all outputs 0, terrain_addr=0 for 20 cycles, no probe_valid.
//  2 X=320,Y=240,S=4, flat ROM (all 300), latency 1: addr 79,80,81 in cycles 1-3.
//    probe_valid in cycle 5 only. ground_y=300, grounded=0, pen=0, walls=0.
//  3 Flat 242, same ball: grounded=1, penetration=2, walls=0.
//    Set hL=230: wall_left=1 (234<244). Set hL=240: wall_left=0 (244 not < 244).
//  4 X=2,S=4 -> colL clamps to 0 (addr 0). X=639,S=4 -> colR clamps to 639 (addr 159).
//    Y=1000,S=1000, hC=0: penetration saturates at 1023.
//  5 frame_start in cycles 0 and 2: one probe_valid (cycle 5), overrun=1 held until Reset.
//    Reset asserted in cycle 3: no probe_valid, all outputs 0.
//  6 RD_LATENCY=2 build, case 2: probe_valid in cycle 6, identical results.

Source files
------------

// File: rtl/terrain_probe.sv
// terrain_probe: once per frame, reads three terrain heights under the ball
// (left edge, centre, right edge) and reports ground contact, penetration depth
// and left/right wall flags for the ball motion stage.
module terrain_probe #(
  parameter int COL_SHIFT  = 2,
  parameter int X_MAX      = 639,
  parameter int STEP_MAX   = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  output logic [9:0] terrain_addr,
  input  logic [9:0] terrain_data,
  output logic       probe_valid,
  output logic [9:0] ground_y,
  output logic       grounded,
  output logic [9:0] penetration,
  output logic       wall_left,
  output logic       wall_right,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_L = 3'd1,
    ISSUE_C = 3'd2,
    ISSUE_R = 3'd3,
    DRAIN   = 3'd4,
    RESULT  = 3'd5
  } state_t;

  // Tags travel alongside each address so returning data is steered by
  // position in the pipe, not by whatever state the FSM is in when it lands.
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_L    = 2'd1;
  localparam logic [1:0] TAG_C    = 2'd2;
  localparam logic [1:0] TAG_R    = 2'd3;
  localparam int         TAG_W    = 2 * (RD_LATENCY + 1);

  state_t            state_q, state_d;
  logic [9:0]        x_q, y_q, s_q;
  logic [9:0]        addr_q, addr_d;
  logic [1:0]        tag_d;
  logic [TAG_W-1:0]  tag_pipe_q;
  logic [1:0]        tag_tail;
  logic [9:0]        h_l_q, h_c_q, h_r_q;
  logic [9:0]        h_l_d, h_c_d, h_r_d;
  logic [9:0]        ground_y_q, penetration_q;
  logic              grounded_q, wall_left_q, wall_right_q, overrun_q;

  // Column arithmetic is 11 bits wide so X+S cannot wrap before clamping.
  logic [10:0]       x_eff, s_eff;
  logic [10:0]       col_l, col_c, col_r, x_plus_s;
  logic [9:0]        addr_l, addr_c, addr_r;
  logic [10:0]       bot, h_c_ext, diff;
  logic              res_grounded, res_wall_l, res_wall_r, res_load;
  logic [9:0]        res_pen;

  // In IDLE the left address is issued straight from the live inputs (same
  // cycle they are latched); afterwards only the latched copy is used.
  assign x_eff    = (state_q == IDLE) ? {1'b0, BallX} : {1'b0, x_q};
  assign s_eff    = (state_q == IDLE) ? {1'b0, BallS} : {1'b0, s_q};
  assign x_plus_s = x_eff + s_eff;
  assign col_l    = (x_eff >= s_eff) ? (x_eff - s_eff) : 11'd0;
  assign col_c    = x_eff;
  assign col_r    = (x_plus_s > 11'(X_MAX)) ? 11'(X_MAX) : x_plus_s;
  assign addr_l   = 10'(col_l >> COL_SHIFT);
  assign addr_c   = 10'(col_c >> COL_SHIFT);
  assign addr_r   = 10'(col_r >> COL_SHIFT);

  assign tag_tail = tag_pipe_q[2*RD_LATENCY +: 2];

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DRAIN ends when the right-column read is landing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = ISSUE_L;
      ISSUE_L: state_d = ISSUE_C;
      ISSUE_C: state_d = ISSUE_R;
      ISSUE_R: state_d = DRAIN;
      DRAIN:   if (tag_tail == TAG_R) state_d = RESULT;
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: address/tag for the upcoming state, valid pulse in RESULT
  always_comb begin
    addr_d      = 10'd0;
    tag_d       = TAG_NONE;
    probe_valid = (state_q == RESULT);
    case (state_d)
      ISSUE_L: begin addr_d = addr_l; tag_d = TAG_L; end
      ISSUE_C: begin addr_d = addr_c; tag_d = TAG_C; end
      ISSUE_R: begin addr_d = addr_r; tag_d = TAG_R; end
      default: ;
    endcase
  end

  // Address register and read-tag shift pipe (tail aligns with returning data)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q     <= 10'd0;
      tag_pipe_q <= '0;
    end else begin
      addr_q     <= addr_d;
      tag_pipe_q <= {tag_pipe_q[TAG_W-3:0], tag_d};
    end
  end

  // Capture ball position when a probe is accepted
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q <= 10'd0;
      y_q <= 10'd0;
      s_q <= 10'd0;
    end else if (state_q == IDLE && frame_start) begin
      x_q <= BallX;
      y_q <= BallY;
      s_q <= BallS;
    end
  end

  // Heights including the sample arriving this cycle, so the last read can
  // feed the results without an extra pipeline stage.
  always_comb begin
    h_l_d = (tag_tail == TAG_L) ? terrain_data : h_l_q;
    h_c_d = (tag_tail == TAG_C) ? terrain_data : h_c_q;
    h_r_d = (tag_tail == TAG_R) ? terrain_data : h_r_q;
  end

  // Height capture registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      h_l_q <= 10'd0;
      h_c_q <= 10'd0;
      h_r_q <= 10'd0;
    end else begin
      h_l_q <= h_l_d;
      h_c_q <= h_c_d;
      h_r_q <= h_r_d;
    end
  end

  // Contact / wall evaluation on 11-bit values (ball bottom can exceed 1023)
  always_comb begin
    bot          = {1'b0, y_q} + {1'b0, s_q};
    h_c_ext      = {1'b0, h_c_d};
    diff         = bot - h_c_ext;
    res_grounded = (bot >= h_c_ext);
    res_pen      = 10'd0;
    if (res_grounded) res_pen = (diff > 11'd1023) ? 10'd1023 : diff[9:0];
    res_wall_l   = (({1'b0, h_l_d} + 11'(STEP_MAX)) < bot);
    res_wall_r   = (({1'b0, h_r_d} + 11'(STEP_MAX)) < bot);
    res_load     = (state_q == DRAIN) && (state_d == RESULT);
  end

  // Result registers: load entering RESULT, hold otherwise
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ground_y_q    <= 10'd0;
      grounded_q    <= 1'b0;
      penetration_q <= 10'd0;
      wall_left_q   <= 1'b0;
      wall_right_q  <= 1'b0;
    end else if (res_load) begin
      ground_y_q    <= h_c_d;
      grounded_q    <= res_grounded;
      penetration_q <= res_pen;
      wall_left_q   <= res_wall_l;
      wall_right_q  <= res_wall_r;
    end
  end

  // Sticky flag: a frame_start arrived while a probe was still in flight
  always_ff @(posedge Clk) begin
    if (Reset)                             overrun_q <= 1'b0;
    else if (frame_start && state_q != IDLE) overrun_q <= 1'b1;
  end

  assign terrain_addr = addr_q;
  assign ground_y     = ground_y_q;
  assign grounded     = grounded_q;
  assign penetration  = penetration_q;
  assign wall_left    = wall_left_q;
  assign wall_right   = wall_right_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_terrain_probe.sv
// Bench for terrain_probe: one instance with 1-cycle ROM latency and one with
// 2-cycle latency, driven in lockstep; expected results go through scoreboards.
module tb_terrain_probe;

  logic       Clk = 1'b0;
  logic       Reset, frame_start;
  logic [9:0] BallX, BallY, BallS;
  logic [9:0] addr1, addr2, data1, data2, data2_a;
  logic [9:0] gy1, gy2, pen1, pen2;
  logic       pv1, pv2, gr1, gr2, wl1, wl2, wr1, wr2, ovr1, ovr2;

  typedef struct {
    logic [9:0] gy;
    logic       gr;
    logic [9:0] pen;
    logic       wl;
    logic       wr;
  } res_t;

  res_t       sb1[$];
  res_t       sb2[$];
  logic [9:0] rom [0:1023];
  int         checks = 0;
  int         errors = 0;
  logic       exp_ovr = 1'b0;

  always #5 Clk = ~Clk;

  terrain_probe #(.RD_LATENCY(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .terrain_addr(addr1), .terrain_data(data1), .probe_valid(pv1),
    .ground_y(gy1), .grounded(gr1), .penetration(pen1),
    .wall_left(wl1), .wall_right(wr1), .overrun(ovr1)
  );

  terrain_probe #(.RD_LATENCY(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .terrain_addr(addr2), .terrain_data(data2), .probe_valid(pv2),
    .ground_y(gy2), .grounded(gr2), .penetration(pen2),
    .wall_left(wl2), .wall_right(wr2), .overrun(ovr2)
  );

  // ROM models: one and two register stages
  always @(posedge Clk) begin
    data1   <= rom[addr1];
    data2_a <= rom[addr2];
    data2   <= data2_a;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 1024; i++) rom[i] = 10'(v);
  endtask

  task automatic pop_check();
    res_t e;
    if (pv1 === 1'b1) begin
      chk("sb1_depth", sb1.size(), 1);
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        chk("ground_y1", gy1, e.gy);
        chk("grounded1", gr1, e.gr);
        chk("penetration1", pen1, e.pen);
        chk("wall_left1", wl1, e.wl);
        chk("wall_right1", wr1, e.wr);
      end
    end
    if (pv2 === 1'b1) begin
      chk("sb2_depth", sb2.size(), 1);
      if (sb2.size() > 0) begin
        e = sb2.pop_front();
        chk("ground_y2", gy2, e.gy);
        chk("grounded2", gr2, e.gr);
        chk("penetration2", pen2, e.pen);
        chk("wall_left2", wl2, e.wl);
        chk("wall_right2", wr2, e.wr);
      end
    end
  endtask

  // One probe starting now (cycle 0); extra_fs>0 raises frame_start again in that cycle
  task automatic run_probe(input int x, input int y, input int s, input int extra_fs);
    res_t e;
    int cl, cr, al, ac, ar, hl, hc, hr, bot, d, ea;
    cl  = (x >= s) ? x - s : 0;
    cr  = (x + s > 639) ? 639 : x + s;
    al  = cl / 4;
    ac  = x / 4;
    ar  = cr / 4;
    hl  = int'(rom[al]);
    hc  = int'(rom[ac]);
    hr  = int'(rom[ar]);
    bot = y + s;
    d   = bot - hc;
    e.gy  = 10'(hc);
    e.gr  = (bot >= hc);
    e.pen = (bot >= hc) ? ((d > 1023) ? 10'd1023 : 10'(d)) : 10'd0;
    e.wl  = (hl + 4) < bot;
    e.wr  = (hr + 4) < bot;
    sb1.push_back(e);
    sb2.push_back(e);
    BallX = 10'(x); BallY = 10'(y); BallS = 10'(s);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    BallX = 10'($urandom_range(0, 639));
    BallY = 10'($urandom_range(0, 1023));
    BallS = 10'($urandom_range(0, 63));
    for (int k = 1; k <= 7; k++) begin
      if (k == extra_fs) frame_start = 1'b1;
      ea = (k == 1) ? al : (k == 2) ? ac : (k == 3) ? ar : 0;
      chk("addr1", addr1, ea);
      chk("addr2", addr2, ea);
      chk("probe_valid1", pv1, (k == 5));
      chk("probe_valid2", pv2, (k == 6));
      pop_check();
      tick();
      frame_start = 1'b0;
    end
    if (extra_fs > 0) exp_ovr = 1'b1;
    chk("overrun1", ovr1, exp_ovr);
    chk("overrun2", ovr2, exp_ovr);
    $display("probe x=%0d y=%0d s=%0d extra_fs=%0d: exp gy=%0d gr=%0d pen=%0d wl=%0d wr=%0d",
             x, y, s, extra_fs, e.gy, e.gr, e.pen, e.wl, e.wr);
  endtask

  // Probe aborted by Reset asserted in cycle 3
  task automatic reset_abort();
    BallX = 10'd320; BallY = 10'd240; BallS = 10'd4;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_ovr = 1'b0;
    chk("abort_out1", {addr1, gy1, gr1, pen1, wl1, wr1, ovr1, pv1}, 0);
    chk("abort_out2", {addr2, gy2, gr2, pen2, wl2, wr2, ovr2, pv2}, 0);
    for (int k = 5; k <= 10; k++) begin
      chk("abort_pv1", pv1, 0);
      chk("abort_pv2", pv2, 0);
      tick();
    end
    $display("reset abort at cycle 3: outputs cleared, no probe_valid expected");
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0;
    BallX = 10'd0; BallY = 10'd0; BallS = 10'd0;
    fill(300);
    tick();
    tick();
    Reset = 1'b0;

    // Idle after reset
    chk("reset_out1", {gy1, gr1, pen1, wl1, wr1, ovr1}, 0);
    chk("reset_out2", {gy2, gr2, pen2, wl2, wr2, ovr2}, 0);
    for (int k = 0; k < 20; k++) begin
      chk("idle_addr1", addr1, 0);
      chk("idle_addr2", addr2, 0);
      chk("idle_pv1", pv1, 0);
      chk("idle_pv2", pv2, 0);
      tick();
    end
    $display("idle: 20 cycles checked");

    // Flat terrain above ball
    fill(300);
    run_probe(320, 240, 4, 0);

    // Grounded, then left-wall threshold
    fill(242);
    run_probe(320, 240, 4, 0);
    rom[79] = 10'd230;
    run_probe(320, 240, 4, 0);
    rom[79] = 10'd240;
    run_probe(320, 240, 4, 0);
    rom[81] = 10'd200;
    run_probe(320, 240, 4, 0);

    // Clamping and saturation
    for (int i = 0; i < 1024; i++) rom[i] = 10'(200 + (i % 97));
    run_probe(2, 240, 4, 0);
    run_probe(639, 240, 4, 0);
    run_probe(100, 290, 0, 0);
    fill(0);
    run_probe(320, 1000, 1000, 0);

    // Overrun: second frame_start in cycle 2, then held across a clean probe
    fill(250);
    run_probe(300, 246, 8, 2);
    run_probe(40, 200, 20, 0);
    reset_abort();
    // frame_start during dut1's RESULT cycle is busy too
    run_probe(500, 248, 6, 5);
    reset_abort();
    run_probe(320, 240, 4, 0);

    chk("sb1_left", sb1.size(), 0);
    chk("sb2_left", sb2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
